// File: rtl/bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// bcd_conv_sched
// Shares one bin2BCD converter between two requesters (port 0 = temperature
// sample, port 1 = user setpoint). Requests are granted round-robin, the
// 7-bit operand is clamped to 0..99, the converter is held in reset with the
// operand applied, released for a fixed run time, and the two BCD digits are
// captured and offered to the display logic over a valid/ready handshake.
//
// Ports:
//   clk, reset              rising-edge clock, async active-low reset
//   req0_valid/data/ready   port 0 request (accept on valid && ready)
//   req1_valid/data/ready   port 1 request
//   conv_rst_n, conv_bin    converter reset (low = load) and operand
//   conv_bcd1, conv_bcd2    converter units / tens digits
//   out_valid, out_ready    result handshake
//   out_tens, out_units     captured digits (passed through unchanged)
//   out_src, out_sat        originating port, operand was clamped
//   out_err                 a captured digit was above 9
//   busy                    high in every state except IDLE
// ---------------------------------------------------------------------------
module bcd_conv_sched #(
   parameter int RST_CYCLES  = 2,
   parameter int CONV_CYCLES = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [6:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [6:0] req1_data,
   output logic       req1_ready,
   output logic       conv_rst_n,
   output logic [6:0] conv_bin,
   input  logic [3:0] conv_bcd1,
   input  logic [3:0] conv_bcd2,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_tens,
   output logic [3:0] out_units,
   output logic       out_src,
   output logic       out_sat,
   output logic       out_err,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, OUT} state_t;

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             src;
   logic             sat;
   logic             grant;
   logic             accept;
   logic [6:0]       sel_data;

   // Round-robin: on contention the port that did not win last time goes.
   always_comb begin
      if (req0_valid && req1_valid) grant = ~last_grant;
      else                          grant = req1_valid;
      accept   = (state == IDLE) && (req0_valid || req1_valid);
      sel_data = grant ? req1_data : req0_data;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)           state_nxt = LOAD;
         LOAD:    if (cnt == RST_LAST)  state_nxt = RUN;
         RUN:     if (cnt == CONV_LAST) state_nxt = CAPTURE;
         CAPTURE:                       state_nxt = OUT;
         OUT:     if (out_ready)        state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; converter runs only in RUN and CAPTURE.
   always_comb begin
      req0_ready = (state == IDLE) && req0_valid && !grant;
      req1_ready = (state == IDLE) && req1_valid &&  grant;
      conv_rst_n = (state == RUN) || (state == CAPTURE);
      busy       = (state != IDLE);
   end

   // Phase counter: cleared on every state change, counts inside LOAD/RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  cnt <= '0;
      else if (state_nxt != state) cnt <= '0;
      else if (state == LOAD || state == RUN) cnt <= cnt + 1'b1;
   end

   // Request capture and operand clamp
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant <= 1'b1;
         src        <= 1'b0;
         sat        <= 1'b0;
         conv_bin   <= '0;
      end else if (accept) begin
         last_grant <= grant;
         src        <= grant;
         if (sel_data > 7'd99) begin
            conv_bin <= 7'd99;
            sat      <= 1'b1;
         end else begin
            conv_bin <= sel_data;
            sat      <= 1'b0;
         end
      end
   end

   // Result capture and handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_tens  <= '0;
         out_units <= '0;
         out_src   <= 1'b0;
         out_sat   <= 1'b0;
         out_err   <= 1'b0;
      end else if (state == CAPTURE) begin
         out_valid <= 1'b1;
         out_tens  <= conv_bcd2;
         out_units <= conv_bcd1;
         out_src   <= src;
         out_sat   <= sat;
         out_err   <= (conv_bcd2 > 4'd9) || (conv_bcd1 > 4'd9);
      end else if (state == OUT && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
